// File: rtl/core_ctrl_axi_master.sv
// core_ctrl_axi_master
// AXI4-Lite master that turns single valid/ready register requests from a CPU
// port into AW/W/B or AR/R transactions against the core-management register
// block. One transaction is outstanding at a time. Completion is reported as a
// one-cycle resp_valid pulse carrying read data and an error flag.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | req_ready high, waiting for a request
// WR_ADDR_DATA | awvalid/wvalid driven, each drops after its own handshake
// WR_RESP      | bready high, waiting for bvalid
// RD_ADDR      | arvalid driven, waiting for arready
// RD_DATA      | rready high, waiting for rvalid
// RESP         | resp_valid pulse, back to IDLE next cycle

module core_ctrl_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                busy,

    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,

    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,

    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,

    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,

    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } state_t;

    state_t              state_q;
    logic                req_ready_q;
    logic                busy_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                resp_err_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                aw_done_q;
    logic                w_done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic aw_hs;
    logic w_hs;
    logic aw_done_d;
    logic w_done_d;

    // Handshake strobes and "done including this cycle" flags for the write phase.
    assign aw_hs     = awvalid_q & awready;
    assign w_hs      = wvalid_q & wready;
    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q | w_hs;

    // Single registered FSM: every output is a flop updated on state transitions,
    // so no valid can depend combinationally on a ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= (bresp != 2'b00);
                        resp_rdata_q <= '0;
                        busy_q       <= 1'b0;
                        state_q      <= RESP;
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= (rresp != 2'b00);
                        resp_rdata_q <= rdata;
                        busy_q       <= 1'b0;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    awvalid_q   <= 1'b0;
                    wvalid_q    <= 1'b0;
                    bready_q    <= 1'b0;
                    arvalid_q   <= 1'b0;
                    rready_q    <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign awvalid    = awvalid_q;
    assign awaddr     = addr_q;
    assign wvalid     = wvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = '1;
    assign bready     = bready_q;
    assign arvalid    = arvalid_q;
    assign araddr     = addr_q;
    assign rready     = rready_q;

endmodule

// File: tb/tb_core_ctrl_axi_master.sv
// Directed bench for core_ctrl_axi_master: the bench plays the AXI slave
// cycle by cycle and checks outputs 1 ns after each rising edge.
module tb_core_ctrl_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    core_ctrl_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        arready = 0; rvalid = 0; rdata = 32'h0; rresp = 2'b00;
    endtask

    initial begin
        rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        slave_idle();
        tick(); tick();
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        check_eq("rst_readies", {30'd0, bready, rready}, 32'd0);
        rst = 0;
        tick();

        // Write 3 to 0x4, zero-wait slave
        req_valid = 1; req_we = 1; req_addr = 32'h4; req_wdata = 32'h3;
        awready = 1; wready = 1;
        tick();                                   // accept edge
        req_valid = 0;
        check_eq("w0_awvalid", 32'(awvalid), 32'd1);
        check_eq("w0_wvalid", 32'(wvalid), 32'd1);
        check_eq("w0_awaddr", awaddr, 32'h4);
        check_eq("w0_wdata", wdata, 32'h3);
        check_eq("w0_wstrb", 32'(wstrb), 32'hF);
        check_eq("w0_busy", 32'(busy), 32'd1);
        check_eq("w0_req_ready", 32'(req_ready), 32'd0);
        tick();                                   // AW/W handshake
        awready = 0; wready = 0;
        check_eq("w0_valids_drop", {30'd0, awvalid, wvalid}, 32'd0);
        check_eq("w0_bready", 32'(bready), 32'd1);
        check_eq("w0_early_resp", 32'(resp_valid), 32'd0);
        bvalid = 1; bresp = 2'b00;
        tick();                                   // B handshake
        bvalid = 0;
        check_eq("w0_resp_valid", 32'(resp_valid), 32'd1);
        check_eq("w0_resp_err", 32'(resp_err), 32'd0);
        check_eq("w0_resp_rdata", resp_rdata, 32'h0);
        check_eq("w0_busy_drop", 32'(busy), 32'd0);
        check_eq("w0_bready_drop", 32'(bready), 32'd0);
        tick();
        check_eq("w0_resp_pulse", 32'(resp_valid), 32'd0);
        check_eq("w0_req_ready_back", 32'(req_ready), 32'd1);

        // Write with W 4 cycles before AW, slave answers SLVERR
        req_valid = 1; req_we = 1; req_addr = 32'h8; req_wdata = 32'h1;
        tick();
        req_valid = 0;
        wready = 1;
        tick();                                   // W handshake only
        wready = 0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("w1_wvalid_c%0d", i), 32'(wvalid), 32'd0);
            check_eq($sformatf("w1_awvalid_c%0d", i), 32'(awvalid), 32'd1);
            check_eq($sformatf("w1_bready_c%0d", i), 32'(bready), 32'd0);
            awready = (i == 3);
            tick();
        end
        awready = 0;
        check_eq("w1_awvalid_drop", 32'(awvalid), 32'd0);
        check_eq("w1_bready", 32'(bready), 32'd1);
        bvalid = 1; bresp = 2'b10;
        tick();
        bvalid = 0; bresp = 2'b00;
        check_eq("w1_resp_valid", 32'(resp_valid), 32'd1);
        check_eq("w1_resp_err", 32'(resp_err), 32'd1);
        check_eq("w1_bready_drop", 32'(bready), 32'd0);
        tick();
        check_eq("w1_single_resp", 32'(resp_valid), 32'd0);

        // Read 0x1, arready delayed 2 cycles, rresp OKAY
        req_valid = 1; req_we = 0; req_addr = 32'h1;
        tick();
        req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("r0_arvalid_c%0d", i), 32'(arvalid), 32'd1);
            check_eq($sformatf("r0_araddr_c%0d", i), araddr, 32'h1);
            check_eq($sformatf("r0_rready_c%0d", i), 32'(rready), 32'd0);
            arready = (i == 2);
            tick();
        end
        arready = 0;
        check_eq("r0_arvalid_drop", 32'(arvalid), 32'd0);
        check_eq("r0_rready", 32'(rready), 32'd1);
        rvalid = 1; rdata = 32'h1; rresp = 2'b00;
        tick();
        rvalid = 0; rdata = 32'h0;
        check_eq("r0_resp_valid", 32'(resp_valid), 32'd1);
        check_eq("r0_resp_rdata", resp_rdata, 32'h1);
        check_eq("r0_resp_err", 32'(resp_err), 32'd0);
        check_eq("r0_rready_drop", 32'(rready), 32'd0);
        tick();

        // Zero-wait read with SLVERR and non-trivial data
        req_valid = 1; req_we = 0; req_addr = 32'h20;
        arready = 1;
        tick();
        req_valid = 0;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'hDEADBEEF; rresp = 2'b10;
        tick();
        rvalid = 0; rdata = 32'h0; rresp = 2'b00;
        check_eq("r1_resp_valid", 32'(resp_valid), 32'd1);
        check_eq("r1_resp_rdata", resp_rdata, 32'hDEADBEEF);
        check_eq("r1_resp_err", 32'(resp_err), 32'd1);
        tick();

        // req_valid held high: next accept only the cycle after resp_valid
        req_valid = 1; req_we = 0; req_addr = 32'h10;
        arready = 1; rvalid = 1; rdata = 32'h55; rresp = 2'b00;
        tick();                                   // c1 RD_ADDR
        check_eq("bb_c1_req_ready", 32'(req_ready), 32'd0);
        tick();                                   // c2 RD_DATA
        check_eq("bb_c2_req_ready", 32'(req_ready), 32'd0);
        check_eq("bb_c2_busy", 32'(busy), 32'd1);
        tick();                                   // c3 RESP
        check_eq("bb_c3_resp_valid", 32'(resp_valid), 32'd1);
        check_eq("bb_c3_req_ready", 32'(req_ready), 32'd0);
        check_eq("bb_c3_arvalid", 32'(arvalid), 32'd0);
        tick();                                   // c4 IDLE, accept edge follows
        check_eq("bb_c4_req_ready", 32'(req_ready), 32'd1);
        check_eq("bb_c4_resp_valid", 32'(resp_valid), 32'd0);
        tick();                                   // c5 second RD_ADDR
        req_valid = 0;
        check_eq("bb_c5_busy", 32'(busy), 32'd1);
        check_eq("bb_c5_arvalid", 32'(arvalid), 32'd1);
        check_eq("bb_c5_req_ready", 32'(req_ready), 32'd0);
        tick();                                   // c6 RD_DATA
        tick();                                   // c7 RESP
        check_eq("bb_c7_resp_valid", 32'(resp_valid), 32'd1);
        check_eq("bb_c7_rdata", resp_rdata, 32'h55);
        slave_idle();
        tick();

        // Reset while in RD_DATA
        req_valid = 1; req_we = 0; req_addr = 32'h30;
        arready = 1;
        tick();
        req_valid = 0;
        tick();
        arready = 0;
        check_eq("rr_rready", 32'(rready), 32'd1);
        rst = 1;
        tick();
        rst = 0;
        check_eq("rr_arvalid", 32'(arvalid), 32'd0);
        check_eq("rr_rready_drop", 32'(rready), 32'd0);
        check_eq("rr_req_ready", 32'(req_ready), 32'd1);
        check_eq("rr_busy", 32'(busy), 32'd0);
        check_eq("rr_no_resp", 32'(resp_valid), 32'd0);
        rvalid = 1; rdata = 32'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("rr_stray_resp_c%0d", i), 32'(resp_valid), 32'd0);
            check_eq($sformatf("rr_stray_rready_c%0d", i), 32'(rready), 32'd0);
        end
        slave_idle();

        // Recovery: a normal write still completes after the abandoned read
        req_valid = 1; req_we = 1; req_addr = 32'hC; req_wdata = 32'h2;
        awready = 1; wready = 1;
        tick();
        req_valid = 0;
        check_eq("rc_awaddr", awaddr, 32'hC);
        tick();
        awready = 0; wready = 0; bvalid = 1;
        tick();
        bvalid = 0;
        check_eq("rc_resp_valid", 32'(resp_valid), 32'd1);
        check_eq("rc_resp_err", 32'(resp_err), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
